maxpool_relu_stage: RTL and testbench

- Stage directly upstream of the fully connected layer.
- Accepts a raster-order stream of signed conv-layer pixels for one IMG_H x IMG_W feature map.
- Applies non-overlapping POOL x POOL max-pooling fused with ReLU, then an optional arithmetic right shift.
- Presents the flattened OUT_N-element vector (default 9) plus a done flag that drives the FC layer's input vector and enable.

---
 rtl/cnn_pkg.sv | 27 ++
 rtl/pool_addr_gen.sv | 52 +++++
 rtl/maxpool_relu_stage.sv | 117 +++++++++++
 tb/tb_maxpool_relu_stage.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath stages.
//   - default pixel width and feature-map / pooling geometry
//   - FSM state encoding used by the pooling stage
//   - helpers for the pooled vector length and its index width
package cnn_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int IMG_W_DEF  = 6;
    localparam int IMG_H_DEF  = 6;
    localparam int POOL_DEF   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int out_n_calc(input int w, input int h, input int p);
        return (w / p) * (h / p);
    endfunction

    // Width able to index n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// Raster-position tracker for the pooling stage.
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-low reset
//   clear   in   return to row 0 / col 0
//   advance in   one pixel accepted, step to the next raster position
//   idx     out  pooled-window index of the current position
//   last    out  current position is the final pixel of the frame
module pool_addr_gen
    import cnn_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int POOL  = POOL_DEF,
    parameter int IDX_W = idx_width(out_n_calc(IMG_W_DEF, IMG_H_DEF, POOL_DEF))
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    localparam int COL_W = idx_width(IMG_W);
    localparam int ROW_W = idx_width(IMG_H);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (col == COL_W'(IMG_W - 1)) begin
                col <= '0;
                // Wrap the row as well so the counters never leave the map.
                row <= (row == ROW_W'(IMG_H - 1)) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign idx  = IDX_W'((int'(row) / POOL) * (IMG_W / POOL) + int'(col) / POOL);
    assign last = (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));

endmodule

// File: rtl/maxpool_relu_stage.sv
// Fused max-pool + ReLU stage feeding the fully connected layer.
// Consumes one raster-order feature map, keeps a running max per pooling
// window (seeded with 0, which gives the ReLU), and publishes the shifted
// pooled vector with a held done flag.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   start     in   one-cycle pulse, clears accumulators and begins a frame
//   in_valid  in   in_data valid
//   in_ready  out  pixel accepted this cycle when in_valid is high
//   in_data   in   signed pixel, row-major raster order
//   pool_out  out  pooled vector, index (r/POOL)*(IMG_W/POOL) + c/POOL
//   done      out  pool_out holds a complete frame (level)
//   busy      out  frame accumulation in progress
module maxpool_relu_stage
    import cnn_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int IMG_W  = IMG_W_DEF,
    parameter  int IMG_H  = IMG_H_DEF,
    parameter  int POOL   = POOL_DEF,
    parameter  int SHIFT  = 0,
    localparam int OUT_N  = out_n_calc(IMG_W, IMG_H, POOL)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic signed [DATA_W-1:0] pool_out [OUT_N],
    output logic                     done,
    output logic                     busy
);

    localparam int IDX_W = idx_width(OUT_N);

    if ((IMG_W % POOL) != 0 || (IMG_H % POOL) != 0) begin : g_geom_check
        $error("maxpool_relu_stage: IMG_W and IMG_H must be multiples of POOL");
    end

    function automatic logic signed [DATA_W-1:0] shift_out(input logic signed [DATA_W-1:0] v);
        return v >>> SHIFT;
    endfunction

    state_t                  state, state_nx;
    logic                    accept;
    logic                    last;
    logic [IDX_W-1:0]        idx;
    logic                    fin_p1;
    logic signed [DATA_W-1:0] acc [OUT_N];

    assign in_ready = (state == ACCUM);
    assign busy     = (state == ACCUM);
    // start wins over a pixel presented in the same cycle.
    assign accept   = in_valid && in_ready && !start;

    pool_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .POOL  (POOL),
        .IDX_W (IDX_W)
    ) u_addr (
        .clk     (clk),
        .rst     (rst),
        .clear   (start),
        .advance (accept),
        .idx     (idx),
        .last    (last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = ACCUM;
            ACCUM:   if (start) state_nx = ACCUM;
                     else if (accept && last) state_nx = DONE;
            DONE:    if (start) state_nx = ACCUM;
            default: state_nx = IDLE;
        endcase
    end

    // Stage p0: running max per window, accumulators seeded with 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < OUT_N; k++) acc[k] <= '0;
        end else if (start) begin
            for (int k = 0; k < OUT_N; k++) acc[k] <= '0;
        end else if (accept) begin
            acc[idx] <= (in_data > acc[idx]) ? in_data : acc[idx];
        end
    end

    // Stage p1: one edge after the last pixel, acc already includes it, so
    // publishing the whole array here never loses the final window update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fin_p1 <= 1'b0;
            done   <= 1'b0;
            for (int k = 0; k < OUT_N; k++) pool_out[k] <= '0;
        end else begin
            fin_p1 <= accept && last;
            if (start) begin
                done <= 1'b0;
            end else if (fin_p1) begin
                done <= 1'b1;
                for (int k = 0; k < OUT_N; k++) pool_out[k] <= shift_out(acc[k]);
            end
        end
    end

endmodule

// File: tb/tb_maxpool_relu_stage.sv
module tb_maxpool_relu_stage;

    localparam int DW = 32;
    localparam int N  = 9;
    localparam int NPIX = 36;

    localparam int RAMP0 [N] = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
    localparam int RAMP1 [N] = '{3, 4, 5, 9, 10, 11, 15, 16, 17};

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] in_data = '0;

    logic                 in_ready, done, busy;
    logic                 in_ready_s, done_s, busy_s;
    logic signed [DW-1:0] pool_out   [N];
    logic signed [DW-1:0] pool_out_s [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    maxpool_relu_stage #(.DATA_W(DW), .IMG_W(6), .IMG_H(6), .POOL(2), .SHIFT(0)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .pool_out(pool_out), .done(done), .busy(busy)
    );

    maxpool_relu_stage #(.DATA_W(DW), .IMG_W(6), .IMG_H(6), .POOL(2), .SHIFT(1)) dut_s (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .pool_out(pool_out_s), .done(done_s), .busy(busy_s)
    );

    task automatic chk(input string tag, input logic signed [DW-1:0] obs, input logic signed [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind 0: ramp, kind 1: negatives with +3 at (0,1) and -8 at (0,2), kind 2: all ones
    function automatic logic signed [DW-1:0] pix(input int kind, input int i);
        case (kind)
            0:       return DW'(i);
            1:       return (i == 1) ? 32'sd3 : (i == 2) ? -32'sd8 : -32'sd5;
            default: return 32'sd1;
        endcase
    endfunction

    // Pixel offered alongside start must be ignored.
    task automatic do_start();
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'sd100;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic feed(input int kind, input int n, input bit stall);
        int  sent = 0;
        int  cyc  = 0;
        bit  take;
        while (sent < n && cyc < 1000) begin
            in_valid = stall ? (cyc % 3 == 0) : 1'b1;
            in_data  = pix(kind, sent);
            if (stall) chk("busy_during_stall", DW'(busy), 1);
            take = in_valid && in_ready;
            tick();
            if (take) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        if (sent < n) chk("feed_timeout", sent, n);
    endtask

    task automatic finish_checks();
        chk("in_ready_after_last", DW'(in_ready), 0);
        chk("done_at_last_edge", DW'(done), 0);
        tick();
        chk("done_after_last", DW'(done), 1);
        chk("done_s_after_last", DW'(done_s), 1);
        chk("busy_after_last", DW'(busy), 0);
    endtask

    task automatic check_vec(input string tag, input int kind);
        int e0, e1;
        for (int k = 0; k < N; k++) begin
            case (kind)
                0:       begin e0 = RAMP0[k];           e1 = RAMP1[k];           end
                1:       begin e0 = (k == 0) ? 3 : 0;   e1 = (k == 0) ? 1 : 0;   end
                default: begin e0 = 1;                  e1 = 0;                  end
            endcase
            chk($sformatf("%s pool_out[%0d]", tag, k), pool_out[k], e0);
            chk($sformatf("%s shift pool_out[%0d]", tag, k), pool_out_s[k], e1);
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst in_ready", DW'(in_ready), 0);
        chk("rst done", DW'(done), 0);
        chk("rst busy", DW'(busy), 0);
        for (int k = 0; k < N; k++) chk($sformatf("rst pool_out[%0d]", k), pool_out[k], 0);
        rst = 1'b1;
        tick();

        // Reset mid-frame after 10 pixels
        do_start();
        chk("busy_after_start", DW'(busy), 1);
        feed(0, 10, 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst in_ready", DW'(in_ready), 0);
        chk("midrst done", DW'(done), 0);
        chk("midrst busy", DW'(busy), 0);
        for (int k = 0; k < N; k++) chk($sformatf("midrst pool_out[%0d]", k), pool_out[k], 0);
        tick();
        rst = 1'b1;
        tick();

        // Ramp frame, continuous valid
        do_start();
        feed(0, NPIX, 1'b0);
        finish_checks();
        check_vec("ramp", 0);

        // Negatives / ReLU
        do_start();
        chk("neg done_cleared", DW'(done), 0);
        chk("neg hold pool_out[0]", pool_out[0], 7);
        feed(1, NPIX, 1'b0);
        finish_checks();
        check_vec("neg", 1);

        // Ramp with stalls
        do_start();
        feed(0, NPIX, 1'b1);
        finish_checks();
        check_vec("stall", 0);

        // Restart/hold: start, partial frame, restart, ones frame
        do_start();
        chk("restart done_cleared", DW'(done), 0);
        feed(0, 20, 1'b0);
        chk("hold busy", DW'(busy), 1);
        chk("hold done", DW'(done), 0);
        for (int k = 0; k < N; k++) chk($sformatf("hold pool_out[%0d]", k), pool_out[k], RAMP0[k]);
        do_start();
        feed(2, NPIX, 1'b0);
        finish_checks();
        check_vec("ones", 2);

        // Done stays held while idle
        tick();
        tick();
        chk("done_held", DW'(done), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
